// File: rtl/prio_encoder_arb.sv
// Purpose: sticky request capture plus fixed-priority or round-robin index encoder on a valid/ready port.
// Latency: req high at edge t -> pending after t -> out_valid after t+1; one grant per cycle when accepted back to back.
// Backpressure: while out_valid & !out_ready the grant is held stable and new requests keep accumulating in pending.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   req        N request lines; any high cycle sets the matching pending bit
//   out_ready  consumer accepts the current grant this cycle
//   out_valid  out_idx/out_multi carry a valid grant
//   out_idx    encoded index of the granted request
//   out_multi  more than one candidate existed when out_idx was loaded
//   pending    sticky pending register (status/debug)
//   req_drop   one-cycle pulse, one cycle late: a request hit an already-pending bit
module prio_encoder_arb #(
  parameter int N  = 8,
  parameter int RR = 0,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi,
  output logic [N-1:0] pending,
  output logic         req_drop
);

  localparam logic [N-1:0] ONE_N  = N'(1);
  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  // State registers
  logic [N-1:0] pending_q,   pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_multi_q, out_multi_d;
  logic         req_drop_q,  req_drop_d;
  logic [W-1:0] ptr_q,       ptr_d;

  // Combinational helpers
  logic         acc;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic         cand_any;
  logic         cand_multi;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] sel_fp;
  logic [W-1:0] sel_rr;
  logic [W-1:0] sel;
  logic         rr_found;
  int           rr_j;

  // Handshake, clear mask and candidate set.
  always_comb begin
    acc  = out_valid_q & out_ready;
    clr  = acc ? (ONE_N << out_idx_q) : '0;
    cand = pending_q & ~clr;
    cand_any = |cand;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    cand_multi = |(cand & (cand - ONE_N));
    // The index accepted this cycle becomes the new round-robin origin immediately,
    // so the reload that happens on the same edge already searches past it.
    ptr_eff = acc ? out_idx_q : ptr_q;
  end

  // Fixed priority: the last hit in an ascending scan is the highest set bit.
  always_comb begin
    sel_fp = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel_fp = W'(i);
      end
    end
  end

  // Round robin: first set bit at ptr_eff+1, ptr_eff+2, ... wrapping modulo N.
  // Wrapping is done by subtraction so non-power-of-2 N never reaches N..2^W-1.
  always_comb begin
    sel_rr   = '0;
    rr_found = 1'b0;
    rr_j     = 0;
    for (int i = 1; i <= N; i++) begin
      rr_j = int'(ptr_eff) + i;
      if (rr_j >= N) begin
        rr_j = rr_j - N;
      end
      if (!rr_found && cand[rr_j[W-1:0]]) begin
        rr_found = 1'b1;
        sel_rr   = rr_j[W-1:0];
      end
    end
  end

  assign sel = (RR != 0) ? sel_rr : sel_fp;

  // Next-state logic.
  always_comb begin
    // Set wins over clear: a re-request on the accept cycle keeps the bit pending.
    pending_d  = cand | req;
    // Only bits still pending after this cycle's clear count as a dropped merge.
    req_drop_d = |(req & cand);
    ptr_d      = ptr_eff;

    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;

    // Output register reloads when empty or when its grant is being taken.
    if (!out_valid_q || acc) begin
      out_valid_d = cand_any;
      out_multi_d = cand_multi;
      if (cand_any) begin
        out_idx_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
      req_drop_q  <= 1'b0;
      ptr_q       <= PTR_RST;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
      req_drop_q  <= req_drop_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_multi = out_multi_q;
  assign pending   = pending_q;
  assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Purpose: randomized and directed check of prio_encoder_arb against a behavioural model.
// Latency: model advances once per clock; outputs compared on the falling edge.
// Backpressure: out_ready is driven randomly and held low in directed hold scenarios.
module tb_prio_encoder_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: 0 = N8 fixed priority, 1 = N8 round robin, 2 = N5 round robin.
  logic [63:0] req_v [3];
  logic        rdy_v [3];
  logic        rst_v [3];

  logic       vld_a, multi_a, drop_a;
  logic [2:0] idx_a;
  logic [7:0] pend_a;
  logic       vld_b, multi_b, drop_b;
  logic [2:0] idx_b;
  logic [7:0] pend_b;
  logic       vld_c, multi_c, drop_c;
  logic [2:0] idx_c;
  logic [4:0] pend_c;

  prio_encoder_arb #(.N(8), .RR(0)) u_a (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0][7:0]), .out_ready(rdy_v[0]),
    .out_valid(vld_a), .out_idx(idx_a), .out_multi(multi_a), .pending(pend_a), .req_drop(drop_a));

  prio_encoder_arb #(.N(8), .RR(1)) u_b (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1][7:0]), .out_ready(rdy_v[1]),
    .out_valid(vld_b), .out_idx(idx_b), .out_multi(multi_b), .pending(pend_b), .req_drop(drop_b));

  prio_encoder_arb #(.N(5), .RR(1)) u_c (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2][4:0]), .out_ready(rdy_v[2]),
    .out_valid(vld_c), .out_idx(idx_c), .out_multi(multi_c), .pending(pend_c), .req_drop(drop_c));

  logic        g_vld   [3];
  logic        g_multi [3];
  logic        g_drop  [3];
  logic [63:0] g_idx   [3];
  logic [63:0] g_pend  [3];

  assign g_vld[0] = vld_a;  assign g_multi[0] = multi_a;  assign g_drop[0] = drop_a;
  assign g_idx[0] = 64'(idx_a);  assign g_pend[0] = 64'(pend_a);
  assign g_vld[1] = vld_b;  assign g_multi[1] = multi_b;  assign g_drop[1] = drop_b;
  assign g_idx[1] = 64'(idx_b);  assign g_pend[1] = 64'(pend_b);
  assign g_vld[2] = vld_c;  assign g_multi[2] = multi_c;  assign g_drop[2] = drop_c;
  assign g_idx[2] = 64'(idx_c);  assign g_pend[2] = 64'(pend_c);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: pending as a bit array, grant chosen by scanning the
  // surviving candidates; "last" is the most recently accepted index.
  typedef struct {
    logic [63:0] pend;
    logic        vld;
    int          idx;
    logic        multi;
    logic        drop;
    int          last;
  } mstate_t;

  mstate_t m [3];
  int      nn [3];
  bit      rrm [3];
  string   nm [3];

  function automatic mstate_t mstep(input mstate_t s, input int n, input bit rr,
                                    input logic [63:0] rq, input logic rdy, input logic rs);
    mstate_t ns;
    bit      c [64];
    int      cnt;
    bit      acc;
    bit      found;
    int      k;
    ns = s;
    if (rs) begin
      ns.pend = '0; ns.vld = 1'b0; ns.idx = 0; ns.multi = 1'b0; ns.drop = 1'b0; ns.last = n - 1;
      return ns;
    end
    acc     = s.vld && rdy;
    cnt     = 0;
    ns.drop = 1'b0;
    ns.pend = '0;
    for (int b = 0; b < n; b++) begin
      c[b] = s.pend[b] && !(acc && b == s.idx);
      if (c[b]) cnt++;
      if (rq[b] && c[b]) ns.drop = 1'b1;
      ns.pend[b] = c[b] || rq[b];
    end
    if (acc) ns.last = s.idx;
    if (!s.vld || acc) begin
      ns.vld   = (cnt > 0);
      ns.multi = (cnt > 1);
      found    = 1'b0;
      if (cnt > 0) begin
        if (rr) begin
          for (int step = 1; step <= n; step++) begin
            k = (ns.last + step) % n;
            if (!found && c[k]) begin
              found  = 1'b1;
              ns.idx = k;
            end
          end
        end else begin
          for (int b = n - 1; b >= 0; b--) begin
            if (!found && c[b]) begin
              found  = 1'b1;
              ns.idx = b;
            end
          end
        end
      end
    end
    return ns;
  endfunction

  // Advance the model with the currently driven inputs, clock once, compare all instances.
  task automatic tick();
    for (int d = 0; d < 3; d++) begin
      m[d] = mstep(m[d], nn[d], rrm[d], req_v[d], rdy_v[d], rst_v[d]);
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check({nm[d], " out_valid"}, 64'(g_vld[d]),   64'(m[d].vld));
      check({nm[d], " out_idx"},   g_idx[d],        64'(m[d].idx));
      check({nm[d], " out_multi"}, 64'(g_multi[d]), 64'(m[d].multi));
      check({nm[d], " pending"},   g_pend[d],       m[d].pend);
      check({nm[d], " req_drop"},  64'(g_drop[d]),  64'(m[d].drop));
    end
  endtask

  task automatic drive(input int d, input logic [63:0] r, input logic rdy, input logic rs);
    req_v[d] = r;
    rdy_v[d] = rdy;
    rst_v[d] = rs;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] r;
    nn[0] = 8; nn[1] = 8; nn[2] = 5;
    rrm[0] = 1'b0; rrm[1] = 1'b1; rrm[2] = 1'b1;
    nm[0] = "fp8"; nm[1] = "rr8"; nm[2] = "rr5";
    for (int d = 0; d < 3; d++) drive(d, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    tick();
    check("reset pending", g_pend[0], 64'h0);
    check("reset out_valid", 64'(g_vld[1]), 64'h0);
    check("reset out_idx", g_idx[2], 64'h0);
    idle_all();
    tick();

    // Fixed priority: two requests drained highest first.
    drive(0, 64'h24, 1'b1, 1'b0);
    tick();
    check("fp pulse pending", g_pend[0], 64'h24);
    check("fp pulse no valid yet", 64'(g_vld[0]), 64'h0);
    drive(0, 64'h0, 1'b1, 1'b0);
    tick();
    check("fp first idx", g_idx[0], 64'd5);
    check("fp first multi", 64'(g_multi[0]), 64'h1);
    tick();
    check("fp second idx", g_idx[0], 64'd2);
    check("fp second multi", 64'(g_multi[0]), 64'h0);
    tick();
    check("fp drained valid", 64'(g_vld[0]), 64'h0);
    check("fp drained pending", g_pend[0], 64'h0);

    // Backpressure: grant 7 held for five cycles, then 7 and 0 accepted.
    drive(0, 64'h81, 1'b0, 1'b0);
    tick();
    drive(0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold valid", 64'(g_vld[0]), 64'h1);
      check("hold idx", g_idx[0], 64'd7);
      check("hold pending", g_pend[0], 64'h81);
    end
    drive(0, 64'h0, 1'b1, 1'b0);
    tick();
    check("release idx", g_idx[0], 64'd0);
    check("release pending", g_pend[0], 64'h01);
    tick();
    check("release done", 64'(g_vld[0]), 64'h0);

    // Set wins and drop detection on bit 3.
    drive(0, 64'h08, 1'b0, 1'b0);
    tick();
    drive(0, 64'h0, 1'b0, 1'b0);
    tick();
    check("sw idx", g_idx[0], 64'd3);
    drive(0, 64'h08, 1'b0, 1'b0);
    tick();
    check("sw drop pulse", 64'(g_drop[0]), 64'h1);
    drive(0, 64'h0, 1'b0, 1'b0);
    tick();
    check("sw drop clears", 64'(g_drop[0]), 64'h0);
    drive(0, 64'h08, 1'b1, 1'b0);
    tick();
    check("sw accept no drop", 64'(g_drop[0]), 64'h0);
    check("sw bit stays", g_pend[0], 64'h08);
    drive(0, 64'h0, 1'b1, 1'b0);
    tick();
    check("sw regrant valid", 64'(g_vld[0]), 64'h1);
    check("sw regrant idx", g_idx[0], 64'd3);
    tick();

    // Round robin fairness with all lines held.
    drive(1, 64'hFF, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rr seq idx", g_idx[1], 64'(k % 8));
      check("rr seq multi", 64'(g_multi[1]), 64'h1);
    end
    drive(1, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) tick();

    // Reset in the middle of a held grant, then pointer restart.
    drive(1, 64'hF0, 1'b0, 1'b0);
    tick();
    drive(1, 64'h0, 1'b0, 1'b0);
    tick();
    check("mid valid before rst", 64'(g_vld[1]), 64'h1);
    check("mid pending before rst", g_pend[1], 64'hF0);
    drive(1, 64'h01, 1'b1, 1'b1);
    tick();
    check("mid rst pending", g_pend[1], 64'h0);
    check("mid rst valid", 64'(g_vld[1]), 64'h0);
    check("mid rst drop", 64'(g_drop[1]), 64'h0);
    drive(1, 64'h81, 1'b1, 1'b0);
    tick();
    drive(1, 64'h0, 1'b1, 1'b0);
    tick();
    check("rr after rst idx", g_idx[1], 64'd0);
    tick();
    check("rr after rst next", g_idx[1], 64'd7);
    tick();

    // Non-power-of-2 width alternates between its two ends.
    drive(2, 64'h11, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("np2 idx", g_idx[2], (k % 2 == 0) ? 64'd0 : 64'd4);
    end
    drive(2, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();

    // Random traffic in three density/backpressure phases.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 3; d++) begin
        r = {$urandom, $urandom};
        if (c < 500) begin
          r = r & {$urandom, $urandom} & {$urandom, $urandom};
          rdy_v[d] = ($urandom_range(0, 3) != 0);
        end else if (c < 1000) begin
          r = r & {$urandom, $urandom};
          rdy_v[d] = ($urandom_range(0, 3) == 0);
        end else begin
          if ($urandom_range(0, 1) == 0) r = 64'h0;
          rdy_v[d] = ($urandom_range(0, 4) != 0);
        end
        req_v[d] = r;
        rst_v[d] = ($urandom_range(0, 199) == 0);
      end
      tick();
      check("np2 idx range", 64'(g_idx[2] < 64'd5), 64'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
